// File: rtl/burst_mem_if.sv
// Initiator/responder bus for burst_mem_responder: one 256-bit line request, four 64-bit beats.
// Handshake: the initiator raises read_i or write_i and holds it until the transaction completes.
// The responder accepts in IDLE, then strobes resp_o for four consecutive beats. Each beat is
// valid only while resp_o is high, and there is no backpressure.
interface burst_mem_if;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        err_o;

  modport master (
    output address_i, read_i, write_i, burst_i,
    input  burst_o, resp_o, err_o
  );

  modport slave (
    input  address_i, read_i, write_i, burst_i,
    output burst_o, resp_o, err_o
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Line-oriented memory responder: fixed LATENCY wait, then a 4-beat read or write burst.
// Optional protocol checker is enabled by defining BURST_MEM_ERR_CHECK_EN.
module burst_mem_responder #(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 256
) (
  input  logic          clk,
  input  logic          rst,
  burst_mem_if.slave    bus,
  output logic [1:0]    dbg_state
);

  localparam int LW = $clog2(DEPTH_LINES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          op_wr;
  logic [LW-1:0] line;
  logic [7:0]    lat_cnt;
  logic [1:0]    beat;
  logic [1:0]    next_beat;
  logic          resp_q;
  logic [63:0]   rdata_q;

  // Stored as 64-bit words so each write beat commits on its own edge.
  logic [63:0]   mem [DEPTH_LINES*4];

  logic          unused_addr;

  assign next_beat   = beat + 2'd1;
  assign unused_addr = ^{bus.address_i[31:5+LW], bus.address_i[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_wr   <= 1'b0;
      line    <= '0;
      lat_cnt <= '0;
      beat    <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read_i || bus.write_i) begin
            op_wr   <= bus.write_i;
            line    <= bus.address_i[5+LW-1:5];
            lat_cnt <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 8'(LATENCY - 1)) begin
            state  <= BURST;
            beat   <= '0;
            resp_q <= 1'b1;
            if (!op_wr) rdata_q <= mem[{line, 2'd0}];
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        BURST: begin
          if (beat == 2'd3) begin
            state   <= DONE;
            resp_q  <= 1'b0;
            rdata_q <= '0;
          end else begin
            beat <= next_beat;
            if (!op_wr) rdata_q <= mem[{line, next_beat}];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the array. Reset forces IDLE asynchronously, so an interrupted write stops cleanly.
  always_ff @(posedge clk) begin
    if (state == BURST && op_wr) mem[{line, beat}] <= bus.burst_i;
  end

  assign bus.resp_o  = resp_q;
  assign bus.burst_o = rdata_q;
  assign dbg_state   = state;

`ifdef BURST_MEM_ERR_CHECK_EN
  logic err_q;
  logic req_drop;

  assign req_drop = op_wr ? !bus.write_i : !bus.read_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((state == IDLE && bus.read_i && bus.write_i) ||
                 ((state == WAIT || state == BURST) && req_drop)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 Parameter LATENCY, 8, idle cycles between request acceptance and first beat; legal range 1..255.
REQ-002 Parameter DEPTH_LINES, 256, number of 256-bit lines stored; power of two, 2..4096.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 address_i  input  32  line address from initiator; bits [4:0] ignored.
REQ-006 read_i  input  1  line read request; held high until the transaction completes.
REQ-007 write_i  input  1  line write request; held high until the transaction completes.
REQ-008 burst_i  input  64  write beat from initiator.
REQ-009 burst_o  output  64  read beat to initiator.
REQ-010 resp_o  output  1  beat strobe; high for exactly 4 consecutive cycles per transaction.
REQ-011 err_o  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, BURST and DONE.
REQ-013 IDLE: on (read_i | write_i), latch op, line index and a 0 latency count -> WAIT; write wins if both are high.
REQ-014 Line index SHALL be address_i[5+log2(DEPTH_LINES)-1:5]; higher bits ignored, so addresses alias modulo DEPTH_LINES*32 bytes.
REQ-015 WAIT SHALL count LATENCY cycles and then -> BURST with beat counter 0; address_i/op changes after acceptance are ignored.
REQ-016 BURST: resp_o=1 for beats 0..3 in order, beat k = line bits [64k+63:64k]; after beat 3 -> DONE.
REQ-017 Read beat k SHALL be driven on burst_o in the same cycle resp_o is high for beat k; burst_o = 0 whenever resp_o = 0.
REQ-018 Write beat k SHALL be sampled from burst_i on the rising edge ending the cycle resp_o is high for beat k, and written to the array on that same edge.
REQ-019 A read of a line written by the immediately preceding transaction SHALL return the new data.
REQ-020 DONE SHALL last exactly 1 cycle with resp_o = 0 and accept no request, then -> IDLE; request-to-first-beat latency is LATENCY+1 cycles, and back-to-back transactions are separated by 2 idle cycles min.
REQ-021 The storage array SHALL NOT be cleared by reset; its contents are undefined until written.

Reset
REQ-022 Asserting rst (low) SHALL immediately force IDLE, resp_o=0, burst_o=0, err_o=0, counters 0, regardless of state.
REQ-023 A write interrupted by reset SHALL retain beats already committed; remaining beats of that line are unchanged.
REQ-024 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro BURST_MEM_ERR_CHECK_EN defined: err_o set and held until reset when read_i & write_i are both high in IDLE, or when the latched request signal drops in WAIT/BURST; the transaction still completes normally.
REQ-026 Macro undefined: err_o tied 0 and no checker logic is built; all other behaviour identical.

Verification
REQ-027 Reset release, read_i=1 at 0x00000040 with LATENCY=8 -> resp_o rises 9 cycles after acceptance, stays high 4 cycles, then 1 DONE cycle.
REQ-028 Write 0x0000_0080 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read 0x80 -> the same 4 beats in order.
REQ-029 DEPTH_LINES=256: write 0x00000020, read 0x00002020 -> identical data (aliasing wrap).
REQ-030 rst low during beat 2 of a write to 0xA0 -> resp_o=0 immediately; later read of 0xA0 returns new beats 0-1, old beats 2-3.
REQ-031 BURST_MEM_ERR_CHECK_EN defined, read_i & write_i both high at 0xC0 -> write performed, err_o=1 until reset; undefined -> err_o stays 0.
REQ-032 read_i dropped in WAIT, changed address_i in BURST -> full 4-beat burst from the latched line, err_o=1 only with the macro defined.
